// File: rtl/dpsram_arb_pkg.sv
// Shared constants, FSM state type and tag-width helper for the dual-port SRAM arbiter.
package dpsram_arb_pkg;

  localparam int AW_DEF = 11;
  localparam int DW_DEF = 128;
  localparam int DEPTH  = 1 << AW_DEF;

  typedef enum logic {INIT, RUN} state_t;

  // Requester index width; never zero so single-requester builds still get a legal vector.
  function automatic int tag_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dpsram_arb_ctrl_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant searched from a priority pointer.
// The pointer moves past the winner on each grant; with no grant it holds, so losers simply keep waiting.
module rr_arb
  import dpsram_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int PW = tag_w(N);

  logic [PW-1:0] ptr;
  logic [PW-1:0] nxt;

  // Winner is the requester at the smallest circular distance from the pointer.
  always_comb begin
    int d;
    int best;
    int sel;
    d    = 0;
    best = N;
    sel  = 0;
    gnt  = '0;
    nxt  = ptr;
    for (int i = 0; i < N; i++) begin
      d = (i >= int'(ptr)) ? (i - int'(ptr)) : (i + N - int'(ptr));
      if (en && req[i] && (d < best)) begin
        best = d;
        sel  = i;
      end
    end
    for (int i = 0; i < N; i++) begin
      gnt[i] = (best < N) && (i == sel);
    end
    if (best < N) begin
      nxt = (sel == N - 1) ? '0 : PW'(sel + 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (|gnt) begin
      ptr <= nxt;
    end
  end

endmodule

// File: rtl/dpsram_arb_ctrl.sv
// Dual-port SRAM arbiter: writes on port A, reads on port B, SRAM controls registered, read data 2 cycles after grant.
// Requesters hold req until granted; optional zero-fill after reset under DPSRAM_ARB_INIT_EN.
module dpsram_arb_ctrl
  import dpsram_arb_pkg::*;
#(
  parameter int NUM_WR = 4,
  parameter int NUM_RD = 4,
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_WR-1:0]    wr_req,
  input  logic [NUM_WR*AW-1:0] wr_addr,
  input  logic [NUM_WR*DW-1:0] wr_data,
  output logic [NUM_WR-1:0]    wr_gnt,
  input  logic [NUM_RD-1:0]    rd_req,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  output logic [NUM_RD-1:0]    rd_gnt,
  output logic [NUM_RD-1:0]    rd_vld,
  output logic [DW-1:0]        rd_data,
  output logic                 init_done,
  output logic                 sram_ena,
  output logic                 sram_wea,
  output logic [AW-1:0]        sram_addra,
  output logic [DW-1:0]        sram_dina,
  output logic                 sram_enb,
  output logic [AW-1:0]        sram_addrb,
  input  logic [DW-1:0]        sram_doutb
);

  localparam int TW = tag_w(NUM_RD);

  state_t        state;
  logic          arb_en;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;
  logic [AW-1:0] ra;
  logic [TW-1:0] ridx;
  logic [TW-1:0] rd_tag1;
  logic [TW-1:0] rd_tag2;
  logic          rd_vld2;
  logic          rd_byp2;
  logic [DW-1:0] byp_data;
  logic          hit;
`ifdef DPSRAM_ARB_INIT_EN
  logic [AW-1:0] init_cnt;
`endif

  assign arb_en = rst_n & init_done;

  rr_arb #(.N(NUM_WR)) u_wr_arb (.clk(clk), .rst_n(rst_n), .en(arb_en), .req(wr_req), .gnt(wr_gnt));
  rr_arb #(.N(NUM_RD)) u_rd_arb (.clk(clk), .rst_n(rst_n), .en(arb_en), .req(rd_req), .gnt(rd_gnt));

  always_comb begin
    wa = '0;
    wd = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      if (wr_gnt[i]) begin
        wa = wr_addr[i*AW +: AW];
        wd = wr_data[i*DW +: DW];
      end
    end
  end

  always_comb begin
    ra   = '0;
    ridx = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (rd_gnt[i]) begin
        ra   = rd_addr[i*AW +: AW];
        ridx = TW'(i);
      end
    end
  end

  // Same-cycle write/read to one address: the SRAM would return stale data, so capture dina instead.
  assign hit = sram_enb & sram_ena & sram_wea & (sram_addra == sram_addrb);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef DPSRAM_ARB_INIT_EN
      state    <= INIT;
      init_cnt <= '0;
`else
      state    <= RUN;
`endif
      init_done  <= 1'b0;
      sram_ena   <= 1'b0;
      sram_wea   <= 1'b0;
      sram_addra <= '0;
      sram_dina  <= '0;
      sram_enb   <= 1'b0;
      sram_addrb <= '0;
      rd_tag1    <= '0;
      rd_tag2    <= '0;
      rd_vld2    <= 1'b0;
      rd_byp2    <= 1'b0;
      byp_data   <= '0;
    end else begin
      init_done <= (state == RUN);
      sram_ena  <= |wr_gnt;
      sram_wea  <= |wr_gnt;
      if (|wr_gnt) begin
        sram_addra <= wa;
        sram_dina  <= wd;
      end
      sram_enb <= |rd_gnt;
      if (|rd_gnt) begin
        sram_addrb <= ra;
        rd_tag1    <= ridx;
      end
      rd_vld2 <= sram_enb;
      rd_tag2 <= rd_tag1;
      rd_byp2 <= hit;
      if (hit) begin
        byp_data <= sram_dina;
      end
`ifdef DPSRAM_ARB_INIT_EN
      if (state == INIT) begin
        sram_ena   <= 1'b1;
        sram_wea   <= 1'b1;
        sram_addra <= init_cnt;
        sram_dina  <= '0;
        init_cnt   <= init_cnt + 1'b1;
        if (&init_cnt) begin
          state <= RUN;
        end
      end
`endif
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_vld[i] = rd_vld2 && (rd_tag2 == TW'(i));
    end
    if (rd_vld2) begin
      rd_data = rd_byp2 ? byp_data : sram_doutb;
    end
  end

endmodule

// File: tb/tb_dpsram_arb_ctrl.sv
// Directed bench for dpsram_arb_ctrl with a behavioural dual-port SRAM behind the controller.
module tb_dpsram_arb_ctrl;

  localparam int NW = 4;
  localparam int NR = 4;
  localparam int AW = 11;
  localparam int DW = 128;
  localparam logic [DW-1:0] A5 = {16{8'hA5}};

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NW-1:0]    wr_req;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic [NW-1:0]    wr_gnt;
  logic [NR-1:0]    rd_req;
  logic [NR*AW-1:0] rd_addr;
  logic [NR-1:0]    rd_gnt;
  logic [NR-1:0]    rd_vld;
  logic [DW-1:0]    rd_data;
  logic             init_done;
  logic             sram_ena;
  logic             sram_wea;
  logic [AW-1:0]    sram_addra;
  logic [DW-1:0]    sram_dina;
  logic             sram_enb;
  logic [AW-1:0]    sram_addrb;
  logic [DW-1:0]    sram_doutb = '0;
  logic [DW-1:0]    mem [0:(1<<AW)-1];

  int vecs = 0;
  int errs = 0;
  logic [3:0] e;

  always #5 clk = ~clk;

  dpsram_arb_ctrl #(.NUM_WR(NW), .NUM_RD(NR), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_vld(rd_vld), .rd_data(rd_data),
    .init_done(init_done),
    .sram_ena(sram_ena), .sram_wea(sram_wea), .sram_addra(sram_addra), .sram_dina(sram_dina),
    .sram_enb(sram_enb), .sram_addrb(sram_addrb), .sram_doutb(sram_doutb)
  );

  // Read-first dual-port RAM: doutb is valid the cycle after enb.
  always @(posedge clk) begin
    if (sram_ena && sram_wea) mem[sram_addra] <= sram_dina;
    if (sram_enb) sram_doutb <= mem[sram_addrb];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int i);
    return {96'h0, 32'hC0DE_0000 + 32'(i)};
  endfunction

  initial begin
`ifdef DPSRAM_ARB_INIT_EN
    int n;
    logic [AW-1:0] exp_a;
`endif
    wr_req = '0; rd_req = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    repeat (2) tick();
    wr_req = '1; rd_req = '1;
    #1;
    chk("rst_wr_gnt", 128'(wr_gnt), 128'h0);
    chk("rst_rd_gnt", 128'(rd_gnt), 128'h0);
    chk("rst_ena", 128'(sram_ena), 128'h0);
    chk("rst_wea", 128'(sram_wea), 128'h0);
    chk("rst_addra", 128'(sram_addra), 128'h0);
    chk("rst_dina", sram_dina, 128'h0);
    chk("rst_enb", 128'(sram_enb), 128'h0);
    chk("rst_addrb", 128'(sram_addrb), 128'h0);
    chk("rst_rd_vld", 128'(rd_vld), 128'h0);
    chk("rst_rd_data", rd_data, 128'h0);
    chk("rst_init_done", 128'(init_done), 128'h0);

    rst_n = 1'b1;
    #1;
    chk("pre_init_wr_gnt", 128'(wr_gnt), 128'h0);
    chk("pre_init_rd_gnt", 128'(rd_gnt), 128'h0);
    chk("pre_init_done", 128'(init_done), 128'h0);

`ifdef DPSRAM_ARB_INIT_EN
    n = 0;
    exp_a = '0;
    while (!init_done && n < 3000) begin
      chk("init_wr_gnt", 128'(wr_gnt), 128'h0);
      chk("init_rd_gnt", 128'(rd_gnt), 128'h0);
      tick();
      n++;
      if (sram_ena && !init_done) begin
        chk("init_addra", 128'(sram_addra), 128'(exp_a));
        chk("init_dina", sram_dina, 128'h0);
        exp_a = exp_a + 1'b1;
      end
    end
    wr_req = '0; rd_req = '0;
    chk("init_done_reached", 128'(init_done), 128'h1);
    rd_req = 4'b1000; rd_addr[3*AW +: AW] = 11'h7FF;
    #1;
    chk("init_rd_gnt3", 128'(rd_gnt), 128'h8);
    tick(); rd_req = '0;
    tick();
    chk("init_rd_vld", 128'(rd_vld), 128'h8);
    chk("init_rd_data", rd_data, 128'h0);
`else
    wr_req = '0; rd_req = '0;
    tick();
    chk("init_done_first_edge", 128'(init_done), 128'h1);
`endif

    // Four readers requesting continuously rotate from reader 0.
    rd_req = '1;
    for (int i = 0; i < NR; i++) rd_addr[i*AW +: AW] = AW'(11'h200 + i);
    for (int c = 0; c < 5; c++) begin
      #1;
      e = 4'b0001 << (c % 4);
      chk("rr_gnt", 128'(rd_gnt), 128'(e));
      if (c >= 2) begin
        e = 4'b0001 << ((c - 2) % 4);
        chk("rr_vld", 128'(rd_vld), 128'(e));
      end
      tick();
    end
    rd_req = '0;
    chk("rr_vld_tail0", 128'(rd_vld), 128'h8);
    tick();
    chk("rr_vld_tail1", 128'(rd_vld), 128'h1);
    tick();
    chk("rr_vld_idle", 128'(rd_vld), 128'h0);

    // Write then read: writer 0 writes, reader 2 reads three cycles later.
    wr_req = 4'b0001; wr_addr[0 +: AW] = 11'h010; wr_data[0 +: DW] = A5;
    #1;
    chk("wr_gnt0", 128'(wr_gnt), 128'h1);
    tick(); wr_req = '0;
    chk("wr_ena", 128'(sram_ena), 128'h1);
    chk("wr_wea", 128'(sram_wea), 128'h1);
    chk("wr_addra", 128'(sram_addra), 128'h010);
    chk("wr_dina", sram_dina, A5);
    tick();
    chk("wr_ena_off", 128'(sram_ena), 128'h0);
    tick();
    rd_req = 4'b0100; rd_addr[2*AW +: AW] = 11'h010;
    #1;
    chk("rd_gnt2", 128'(rd_gnt), 128'h4);
    tick(); rd_req = '0;
    chk("rd_enb", 128'(sram_enb), 128'h1);
    chk("rd_addrb", 128'(sram_addrb), 128'h010);
    chk("rd_vld_early", 128'(rd_vld), 128'h0);
    tick();
    chk("rd_vld2", 128'(rd_vld), 128'h4);
    chk("rd_data_a5", rd_data, A5);
    tick();
    chk("rd_vld_after", 128'(rd_vld), 128'h0);

    // Collision: same address written and read in one cycle.
    wr_req = 4'b0010; wr_addr[1*AW +: AW] = 11'h3FF; wr_data[1*DW +: DW] = 128'h1234;
    rd_req = 4'b0001; rd_addr[0 +: AW] = 11'h3FF;
    #1;
    chk("col_wr_gnt", 128'(wr_gnt), 128'h2);
    chk("col_rd_gnt", 128'(rd_gnt), 128'h1);
    tick(); wr_req = '0; rd_req = '0;
    chk("col_addra", 128'(sram_addra), 128'h3FF);
    chk("col_addrb", 128'(sram_addrb), 128'h3FF);
    tick();
    chk("col_vld", 128'(rd_vld), 128'h1);
    chk("col_data", rd_data, 128'h1234);
    tick();
    rd_req = 4'b0010; rd_addr[1*AW +: AW] = 11'h3FF;
    #1;
    chk("col_reread_gnt", 128'(rd_gnt), 128'h2);
    tick(); rd_req = '0;
    tick();
    chk("col_reread_vld", 128'(rd_vld), 128'h2);
    chk("col_reread_data", rd_data, 128'h1234);
    tick();

    // Back-to-back: fill 8 words, then reader 3 streams them.
    wr_req = 4'b0100;
    for (int c = 0; c < 8; c++) begin
      wr_addr[2*AW +: AW] = AW'(11'h100 + c);
      wr_data[2*DW +: DW] = pat(c);
      #1;
      chk("b2b_wr_gnt", 128'(wr_gnt), 128'h4);
      tick();
    end
    wr_req = '0;
    tick(); tick();
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        rd_req = 4'b1000; rd_addr[3*AW +: AW] = AW'(11'h100 + c);
      end else begin
        rd_req = '0;
      end
      #1;
      if (c < 8) chk("b2b_rd_gnt", 128'(rd_gnt), 128'h8);
      if (c >= 2) begin
        chk("b2b_rd_vld", 128'(rd_vld), 128'h8);
        chk("b2b_rd_data", rd_data, pat(c - 2));
      end
      tick();
    end
    chk("b2b_idle", 128'(rd_vld), 128'h0);

    // Reset while a read is in flight.
    rd_req = 4'b0010; rd_addr[1*AW +: AW] = 11'h105;
    #1;
    chk("mid_rd_gnt", 128'(rd_gnt), 128'h2);
    tick(); rd_req = '0;
    chk("mid_enb", 128'(sram_enb), 128'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_enb_rst", 128'(sram_enb), 128'h0);
    chk("mid_addrb_rst", 128'(sram_addrb), 128'h0);
    chk("mid_ena_rst", 128'(sram_ena), 128'h0);
    chk("mid_addra_rst", 128'(sram_addra), 128'h0);
    chk("mid_dina_rst", sram_dina, 128'h0);
    chk("mid_vld_rst", 128'(rd_vld), 128'h0);
    chk("mid_data_rst", rd_data, 128'h0);
    chk("mid_init_rst", 128'(init_done), 128'h0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("mid_vld_hold", 128'(rd_vld), 128'h0);
    end
    rst_n = 1'b1;
`ifndef DPSRAM_ARB_INIT_EN
    tick();
    chk("mid_init_again", 128'(init_done), 128'h1);
    rd_req = '1;
    #1;
    chk("mid_ptr_reset", 128'(rd_gnt), 128'h1);
    rd_req = '0;
`endif
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/dpsram_arb_ctrl.md
# dpsram_arb_ctrl

Arbitrating controller for the 128-bit × 2K dual-port packet-buffer SRAM. It shares the SRAM among NUM_WR write requesters on port A and NUM_RD read requesters on port B, each side with its own round-robin arbiter. It registers all SRAM control signals and returns tagged read data with a fixed latency. It forwards same-address write data to readers and, optionally, zero-fills the memory after reset.

## Interface
- NUM_WR, 4, number of write requesters (≥1)
- NUM_RD, 4, number of read requesters (≥1)
- AW, 11, SRAM address width (depth 2^AW)
- DW, 128, SRAM data width

- clk  in  1  single clock for controller and both SRAM ports
- rst_n  in  1  asynchronous active-low reset
- wr_req  in  NUM_WR  write request per requester
- wr_addr  in  NUM_WR*AW  flattened write addresses, requester i at [i*AW +: AW]
- wr_data  in  NUM_WR*DW  flattened write data
- wr_gnt  out  NUM_WR  one-hot grant, combinational
- rd_req  in  NUM_RD  read request per requester
- rd_addr  in  NUM_RD*AW  flattened read addresses
- rd_gnt  out  NUM_RD  one-hot grant, combinational
- rd_vld  out  NUM_RD  one-hot read-data valid, identifies the owner
- rd_data  out  DW  read data, shared by all readers
- init_done  out  1  high once requests are accepted
- sram_ena, sram_wea  out  1  port A enable/write, registered
- sram_addra  out  AW  registered
- sram_dina  out  DW  registered
- sram_enb  out  1  port B enable, registered; port B web tied 0 at top level
- sram_addrb  out  AW  registered
- sram_doutb  in  DW  port B data, valid the cycle after sram_enb

## Operation
- Port A is write-only and port B is read-only, so reads and writes proceed concurrently without stalls.
- A transfer is accepted in a cycle where req[i] & gnt[i]. The requester holds addr/data stable while req is high and not granted.
- Each side has a round-robin arbiter with one priority pointer:
  - Search starts at the pointer.
  - After a grant to index k, the pointer becomes (k+1) mod N.
  - With no grant, the pointer holds.
- Grants are forced to 0 while rst_n is low and while init_done=0.
- Reset state:
  - all sram_* outputs 0
  - rd_vld 0, rd_data 0
  - both pointers 0
  - init_done 0
- Collision bypass: if registered port A (wea=1) and port B drive the same address in the same cycle, the read returns the new sram_dina value, held in a bypass register. It does not use sram_doutb.
- Init FSM with macro enabled:
  - INIT: sweeps addra from 0 to 2^AW−1, one write per cycle, dina=0.
  - INIT → RUN after the last address. init_done rises in the cycle after the last INIT write.
  - RUN is terminal until reset.
- Reset asserted mid-operation aborts the sweep and any in-flight reads. rd_vld never asserts for reads that were cut off.

## Timing
- Request accepted in cycle T.
- sram_* controls valid in T+1. Writes commit at the end of T+1.
- Reads:
  - sram_doutb valid in T+2.
  - rd_vld[i] and rd_data are driven in T+2, combinationally from sram_doutb (or from the bypass register) through a 2-stage tag pipeline.
- A write accepted in T is visible to a read accepted in T (via bypass) and to any later read.
- Throughput: one write and one read per cycle, back-to-back.
- Worst-case grant wait: N−1 cycles when all N requesters are asserting continuously.

## Configuration
- DPSRAM_ARB_INIT_EN defined:
  - After reset, the controller zero-fills all 2^AW words, taking 2^AW cycles.
  - init_done rises at cycle 2^AW after rst_n deasserts.
- DPSRAM_ARB_INIT_EN undefined:
  - No INIT state; the FSM resets directly into RUN.
  - init_done is 1 from the first clock edge after rst_n deasserts.
  - Memory contents are not initialised.

## Structure
- Package dpsram_arb_pkg holds:
  - AW_DEF, DW_DEF and DEPTH constants
  - the state typedef (INIT, RUN)
  - the read tag width function, $clog2(NUM_RD) with a minimum of 1
- Sub-module rr_arb, parameterised by N: req in, one-hot gnt out, pointer update on grant. Instantiated once for writes and once for reads.
- The top level holds the FSM, registered SRAM drive, the tag/valid pipeline and the bypass compare.

## Test plan
- Init (macro on): release reset, hold all reqs high → grants 0 for 2048 cycles; addra sweeps 0..2047 with dina=0; init_done rises at cycle 2048; a subsequent read of 0x7FF returns 0.
- Write then read: writer 0 writes 0xA5…A5 to 0x010 in T; reader 2 reads 0x010 in T+3 → rd_vld=4'b0100 and rd_data=0xA5…A5 in T+5.
- Round-robin: all four readers request continuously → rd_gnt sequence 0001, 0010, 0100, 1000, 0001; every reader is granted once every 4 cycles.
- Collision: writer 1 writes 0x1234 to 0x3FF and reader 0 reads 0x3FF in the same cycle T → rd_data=0x1234 with rd_vld[0] in T+2.
- Reset mid-read: assert rst_n low in T+1 after a read grant in T → rd_vld stays 0 and all sram_* outputs go to 0 immediately.
- Back-to-back: reader 3 alone requests 8 consecutive addresses → 8 consecutive rd_vld[3] pulses with the correct data order, with no gaps.
